// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: state codes, operator codes, datapath width.
package calc_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    EXEC   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;
endpackage

// File: rtl/calc_op_decode.sv
// Operator decode: one-hot ALU enables while executing, and the zero-extended result select.
module calc_op_decode
  import calc_pkg::*;
(
  input  logic             exec_i,
  input  logic [1:0]       op_i,
  input  logic [8:0]       res_add_i,
  input  logic [7:0]       res_sub_i,
  input  logic [15:0]      res_mul_i,
  input  logic [7:0]       res_div_i,
  output logic [3:0]       en_o,
  output logic [RES_W-1:0] res_o
);
  always_comb begin
    en_o = '0;
    if (exec_i) en_o[op_i] = 1'b1;
  end

  always_comb begin
    res_o = '0;
    case (op_e'(op_i))
      OP_ADD:  res_o = {7'b0, res_add_i};
      OP_SUB:  res_o = {8'b0, res_sub_i};
      OP_MUL:  res_o = res_mul_i;
      OP_DIV:  res_o = {8'b0, res_div_i};
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/calc_ctrl_fsm.sv
// Calculator sequencer: gathers A/op/B, holds one ALU enable for HOLD_CYCLES, then
// registers the selected result and presents it with a one-cycle valid pulse.
module calc_ctrl_fsm
  import calc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              num_valid,
  input  logic [DATA_W-1:0] num_data,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic              eq,
  input  logic              clear,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              enable_add,
  output logic              enable_sub,
  output logic              enable_mul,
  output logic              enable_div,
  input  logic [8:0]        result_add,
  input  logic [7:0]        result_sub,
  input  logic [15:0]       result_mul,
  input  logic [7:0]        result_div,
  input  logic              alu_error,
  output logic [15:0]       result,
  output logic              result_valid,
  output logic              negative,
  output logic              err,
  output logic              busy,
  output logic [2:0]        state
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       res_q, res_d;
  logic              rv_q, rv_d, neg_q, neg_d, err_q, err_d;
  logic [3:0]        en;
  logic [15:0]       sel_res;
  logic              num_act, op_act;

  // Only the highest-priority strobe is acted on (clear handled in the register).
  assign op_act  = op_valid & ~eq;
  assign num_act = num_valid & ~op_valid & ~eq;

  calc_op_decode u_dec (
    .exec_i    (state_q == EXEC),
    .op_i      (op_q),
    .res_add_i (result_add),
    .res_sub_i (result_sub),
    .res_mul_i (result_mul),
    .res_div_i (result_div),
    .en_o      (en),
    .res_o     (sel_res)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (num_act) begin
        a_d     = num_data;
        state_d = GOT_A;
      end
      GOT_A: if (op_act) begin
        op_d    = op_code;
        state_d = GOT_OP;
      end else if (num_act) a_d = num_data;
      GOT_OP: if (op_act) op_d = op_code;
      else if (num_act) begin
        b_d     = num_data;
        state_d = GOT_B;
      end
      GOT_B: if (eq) begin
        cnt_d   = 4'(HOLD_CYCLES - 1);
        state_d = EXEC;
      end else if (num_act) b_d = num_data;
      EXEC: if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      else begin
        rv_d = 1'b1;
        if (alu_error) begin
          res_d   = '0;
          err_d   = 1'b1;
          neg_d   = 1'b0;
          state_d = ERR;
        end else begin
          res_d   = sel_res;
          neg_d   = (op_q == OP_SUB) && (a_q < b_q);
          state_d = DONE;
        end
      end
      DONE: if (op_act) begin
        // Chaining only works when the previous result fits in an operand.
        if (res_q[15:8] == '0) begin
          a_d     = res_q[7:0];
          op_d    = op_code;
          state_d = GOT_OP;
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end else if (num_act) begin
        a_d     = num_data;
        neg_d   = 1'b0;
        state_d = GOT_A;
      end
      ERR: if (num_act) begin
        a_d     = num_data;
        err_d   = 1'b0;
        state_d = GOT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a        = a_q;
    alu_b        = b_q;
    enable_add   = en[0];
    enable_sub   = en[1];
    enable_mul   = en[2];
    enable_div   = en[3];
    result       = res_q;
    result_valid = rv_q;
    negative     = neg_q;
    err          = err_q;
    busy         = (state_q == EXEC);
    state        = state_q;
  end
endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Directed bench for calc_ctrl_fsm: two instances (HOLD_CYCLES=1 and 4) sharing stimulus,
// each driving a behavioural ALU.
module tb_calc_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b0, clear = 1'b0;
  logic num_valid = 1'b0, op_valid = 1'b0, eq = 1'b0;
  logic [7:0] num_data = '0;
  logic [1:0] op_code = '0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  // Instance with HOLD_CYCLES=1
  logic [7:0] a1, b1; logic ea1, es1, em1, ed1;
  logic [8:0] ra1; logic [7:0] rs1, rd1; logic [15:0] rm1; logic ae1;
  logic [15:0] res1; logic rv1, neg1, err1, busy1; logic [2:0] st1;
  assign ra1 = {1'b0, a1} + {1'b0, b1};
  assign rs1 = a1 - b1;
  assign rm1 = 16'(a1) * 16'(b1);
  assign rd1 = (b1 == 8'd0) ? 8'd0 : a1 / b1;
  assign ae1 = ed1 && (b1 == 8'd0);

  calc_ctrl_fsm #(.DATA_W(8), .HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num_data(num_data),
    .op_valid(op_valid), .op_code(op_code), .eq(eq), .clear(clear),
    .alu_a(a1), .alu_b(b1), .enable_add(ea1), .enable_sub(es1),
    .enable_mul(em1), .enable_div(ed1), .result_add(ra1), .result_sub(rs1),
    .result_mul(rm1), .result_div(rd1), .alu_error(ae1), .result(res1),
    .result_valid(rv1), .negative(neg1), .err(err1), .busy(busy1), .state(st1)
  );

  // Instance with HOLD_CYCLES=4
  logic [7:0] a4, b4; logic ea4, es4, em4, ed4;
  logic [8:0] ra4; logic [7:0] rs4, rd4; logic [15:0] rm4; logic ae4;
  logic [15:0] res4; logic rv4, neg4, err4, busy4; logic [2:0] st4;
  assign ra4 = {1'b0, a4} + {1'b0, b4};
  assign rs4 = a4 - b4;
  assign rm4 = 16'(a4) * 16'(b4);
  assign rd4 = (b4 == 8'd0) ? 8'd0 : a4 / b4;
  assign ae4 = ed4 && (b4 == 8'd0);

  calc_ctrl_fsm #(.DATA_W(8), .HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .num_valid(num_valid), .num_data(num_data),
    .op_valid(op_valid), .op_code(op_code), .eq(eq), .clear(clear),
    .alu_a(a4), .alu_b(b4), .enable_add(ea4), .enable_sub(es4),
    .enable_mul(em4), .enable_div(ed4), .result_add(ra4), .result_sub(rs4),
    .result_mul(rm4), .result_div(rd4), .alu_error(ae4), .result(res4),
    .result_valid(rv4), .negative(neg4), .err(err4), .busy(busy4), .state(st4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic num(input logic [7:0] v);
    num_valid = 1'b1; num_data = v; cyc(); num_valid = 1'b0;
  endtask

  task automatic op(input logic [1:0] c);
    op_valid = 1'b1; op_code = c; cyc(); op_valid = 1'b0;
  endtask

  task automatic do_eq();
    eq = 1'b1; cyc(); eq = 1'b0;
  endtask

  initial begin
    int k, cnt;
    // Reset state
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_state", st1, 0);
    chk("rst_result", res1, 0);
    chk("rst_flags", {rv1, neg1, err1, busy1}, 0);
    chk("rst_ops", {a1, b1}, 0);
    chk("rst_en", {ed1, em1, es1, ea1}, 0);

    // 15 + 10
    num(15); op(0); num(10); do_eq();
    chk("add_exec_en", {ed1, em1, es1, ea1}, 4'b0001);
    chk("add_busy", {busy1, st1}, {1'b1, 3'd4});
    chk("add_rv_early", rv1, 0);
    cyc();
    chk("add_rv", rv1, 1);
    chk("add_result", res1, 25);
    chk("add_done", {err1, st1, ed1, em1, es1, ea1}, {1'b0, 3'd5, 4'b0000});
    cyc();
    chk("add_rv_pulse", rv1, 0);
    chk("add_hold", res1, 25);

    // 200 * 55, then rejected chaining
    num(200); op(2); num(55); do_eq(); cyc();
    chk("mul_result", res1, 16'h2AF8);
    chk("mul_neg", neg1, 0);
    op(0);
    chk("chain_reject", {err1, st1}, {1'b1, 3'd6});
    num(5);
    chk("err_exit", {err1, st1, a1}, {1'b0, 3'd1, 8'd5});

    // Subtraction with and without underflow
    num(123); op(1); num(215); do_eq();
    chk("sub_en", {ed1, em1, es1, ea1}, 4'b0010);
    cyc();
    chk("sub_wrap", res1, 164);
    chk("sub_neg", neg1, 1);
    num(100); op(1); num(27); do_eq(); cyc();
    chk("sub_pos", res1, 73);
    chk("sub_pos_neg", neg1, 0);

    // Divide by zero
    num(123); op(3); num(0); do_eq();
    chk("div0_en", {ed1, em1, es1, ea1}, 4'b1000);
    cyc();
    chk("div0_err", {rv1, err1, st1}, {1'b1, 1'b1, 3'd6});
    chk("div0_result", res1, 0);
    chk("div0_en_off", {ed1, em1, es1, ea1}, 4'b0000);
    do_eq();
    chk("err_eq_ignored", {err1, st1}, {1'b1, 3'd6});
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_all", {st1, err1, neg1, rv1, busy1, a1, b1, res1}, 0);

    // Chaining 100/27=3, then *50
    num(100); op(3); num(27); do_eq(); cyc();
    chk("div_result", {rv1, res1}, {1'b1, 16'd3});
    op(2);
    chk("chain_state", {st1, a1}, {3'd2, 8'd3});
    num(50); do_eq();
    chk("chain_ops", {a1, b1}, {8'd3, 8'd50});
    cyc();
    chk("chain_result", res1, 150);

    // Priority: op_valid beats num_valid in GOT_A
    clear = 1'b1; cyc(); clear = 1'b0;
    num(9);
    num_valid = 1'b1; num_data = 8'd77; op_valid = 1'b1; op_code = 2'd0; cyc();
    num_valid = 1'b0; op_valid = 1'b0;
    chk("prio_op_num", {st1, a1}, {3'd2, 8'd9});

    // HOLD_CYCLES=4: full add with latency measurement
    clear = 1'b1; cyc(); clear = 1'b0;
    num(9); op(0); num(6); do_eq();
    cnt = 0;
    for (k = 0; k < 20; k++) begin
      if (rv4) break;
      if (ea4) cnt++;
      cyc();
    end
    chk("h4_rv", rv4, 1);
    chk("h4_latency", k, 4);
    chk("h4_en_cycles", cnt, 4);
    chk("h4_result", res4, 15);

    // Ignored strobes, then reset during the second EXEC cycle
    clear = 1'b1; cyc(); clear = 1'b0;
    do_eq();
    chk("idle_eq", {st4, ed4, em4, es4, ea4}, 0);
    op(1);
    chk("idle_op", {st4, ed4, em4, es4, ea4}, 0);
    num(7); op(0); do_eq();
    chk("gotop_eq", {st4, ed4, em4, es4, ea4}, {3'd2, 4'b0000});
    num(3); do_eq();
    chk("h4_exec1", {st4, ea4}, {3'd4, 1'b1});
    cyc();
    chk("h4_exec2", {st4, ea4, busy4}, {3'd4, 1'b1, 1'b1});
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("h4_rst_abort", {st4, ed4, em4, es4, ea4, busy4}, 0);
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      if (rv4) cnt++;
      cyc();
    end
    chk("h4_no_rv", {cnt[3:0], res4}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
